// File: rtl/mem_stage.sv
// Memory stage: registers the EX/MEM boundary, runs load/store accesses against a
// stallable multi-cycle data memory, and hands a registered payload to writeback.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [15:0] ex_result,
  input  logic [15:0] ex_wr_data,
  input  logic        ex_rd_en,
  input  logic        ex_wr_en,
  input  logic [2:0]  ex_dest,
  input  logic        ex_reg_wr,
  input  logic        ex_halt,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_stall,
  input  logic        mem_done,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [15:0] wb_data,
  output logic [2:0]  wb_dest,
  output logic        wb_reg_wr,
  output logic        wb_halt,
  output logic        err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCESS = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_HALTED = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        ld_q, ld_d;
  logic        st_q, st_d;
  logic [2:0]  dest_q, dest_d;
  logic        reg_wr_q, reg_wr_d;
  logic        halt_q, halt_d;

  logic        wb_valid_q, wb_valid_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic [2:0]  wb_dest_q, wb_dest_d;
  logic        wb_reg_wr_q, wb_reg_wr_d;
  logic        wb_halt_q, wb_halt_d;

  logic accept;
  logic complete;

  assign ex_ready  = (state_q == S_IDLE) && (!wb_valid_q || wb_ready);
  assign accept    = ex_valid && ex_ready;

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rd    = (state_q == S_ACCESS) && ld_q;
  assign mem_wr    = (state_q == S_ACCESS) && st_q;

  assign wb_valid  = wb_valid_q;
  assign wb_data   = wb_data_q;
  assign wb_dest   = wb_dest_q;
  assign wb_reg_wr = wb_reg_wr_q;
  assign wb_halt   = wb_halt_q;
  assign err       = (state_q == S_ERROR);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ld_d        = ld_q;
    st_d        = st_q;
    dest_d      = dest_q;
    reg_wr_d    = reg_wr_q;
    halt_d      = halt_q;
    wb_valid_d  = wb_valid_q && !wb_ready;
    wb_data_d   = wb_data_q;
    wb_dest_d   = wb_dest_q;
    wb_reg_wr_d = wb_reg_wr_q;
    wb_halt_d   = wb_halt_q;
    complete    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d   = ex_result;
          wdata_d  = ex_wr_data;
          ld_d     = ex_rd_en;
          st_d     = ex_wr_en;
          dest_d   = ex_dest;
          reg_wr_d = ex_reg_wr;
          halt_d   = ex_halt;
          if ((ex_rd_en && ex_wr_en) || ((ex_rd_en || ex_wr_en) && ex_result[0])) begin
            state_d = S_ERROR;
          end else if (ex_rd_en || ex_wr_en) begin
            state_d = S_ACCESS;
          end else begin
            wb_valid_d  = 1'b1;
            wb_data_d   = ex_result;
            wb_dest_d   = ex_dest;
            wb_reg_wr_d = ex_reg_wr;
            wb_halt_d   = ex_halt;
            state_d     = ex_halt ? S_HALTED : S_IDLE;
          end
        end
      end
      S_ACCESS: begin
        if (!mem_stall) begin
          if (mem_done) begin
            complete = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 8'd0;
          end
        end
      end
      S_WAIT: begin
        if (mem_done) begin
          complete = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase

    // The output register is guaranteed empty here: acceptance required it to drain.
    if (complete) begin
      wb_valid_d  = 1'b1;
      wb_data_d   = ld_q ? mem_rdata : addr_q;
      wb_dest_d   = dest_q;
      wb_reg_wr_d = reg_wr_q && !st_q;
      wb_halt_d   = halt_q;
      state_d     = halt_q ? S_HALTED : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      addr_q      <= 16'd0;
      wdata_q     <= 16'd0;
      ld_q        <= 1'b0;
      st_q        <= 1'b0;
      dest_q      <= 3'd0;
      reg_wr_q    <= 1'b0;
      halt_q      <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= 16'd0;
      wb_dest_q   <= 3'd0;
      wb_reg_wr_q <= 1'b0;
      wb_halt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ld_q        <= ld_d;
      st_q        <= st_d;
      dest_q      <= dest_d;
      reg_wr_q    <= reg_wr_d;
      halt_q      <= halt_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_dest_q   <= wb_dest_d;
      wb_reg_wr_q <= wb_reg_wr_d;
      wb_halt_q   <= wb_halt_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table for single transactions plus
// hand-written sequences for backpressure, halt, throughput and reset mid-access.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [15:0] ex_result;
  logic [15:0] ex_wr_data;
  logic        ex_rd_en;
  logic        ex_wr_en;
  logic [2:0]  ex_dest;
  logic        ex_reg_wr;
  logic        ex_halt;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic        mem_stall;
  logic        mem_done;
  logic        wb_valid;
  logic        wb_ready;
  logic [15:0] wb_data;
  logic [2:0]  wb_dest;
  logic        wb_reg_wr;
  logic        wb_halt;
  logic        err;

  int n_applied = 0;
  int n_mis     = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
    .ex_wr_data(ex_wr_data), .ex_rd_en(ex_rd_en), .ex_wr_en(ex_wr_en),
    .ex_dest(ex_dest), .ex_reg_wr(ex_reg_wr), .ex_halt(ex_halt),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_done(mem_done),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_dest(wb_dest), .wb_reg_wr(wb_reg_wr), .wb_halt(wb_halt), .err(err)
  );

  typedef struct {
    string       name;
    logic [15:0] result;
    logic [15:0] wdata;
    logic        rd;
    logic        wr;
    logic [2:0]  dest;
    logic        reg_wr;
    int          stall_n;   // ACCESS cycles answered with mem_stall
    int          wait_n;    // WAIT cycles before mem_done (0: done in ACCESS, 255: never)
    logic [15:0] rdata;
    logic [15:0] exp_data;
    logic        exp_reg_wr;
    logic        exp_err;
    int          exp_lat;   // edges after the accept edge until wb_valid/err
    int          exp_reqs;  // cycles with mem_rd|mem_wr asserted
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_result = 16'd0; ex_wr_data = 16'd0; ex_rd_en = 1'b0;
    ex_wr_en = 1'b0; ex_dest = 3'd0; ex_reg_wr = 1'b0; ex_halt = 1'b0;
    mem_rdata = 16'd0; mem_stall = 1'b0; mem_done = 1'b0; wb_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive_alu(input logic [15:0] res, input logic [2:0] dest,
                           input logic reg_wr, input logic halt);
    ex_valid = 1'b1; ex_result = res; ex_wr_data = 16'd0; ex_rd_en = 1'b0;
    ex_wr_en = 1'b0; ex_dest = dest; ex_reg_wr = reg_wr; ex_halt = halt;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    int reqs;
    int wcnt;
    bit in_wait;
    @(negedge clk);
    ex_valid = 1'b1; ex_result = v.result; ex_wr_data = v.wdata; ex_rd_en = v.rd;
    ex_wr_en = v.wr; ex_dest = v.dest; ex_reg_wr = v.reg_wr; ex_halt = 1'b0;
    mem_rdata = v.rdata; wb_ready = 1'b1;
    #1 chk({v.name, ".ex_ready"}, 32'(ex_ready), 32'd1);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    lat = 0; reqs = 0; wcnt = 0; in_wait = 0;
    while (!wb_valid && !err && lat < 40) begin
      if (mem_rd || mem_wr) begin
        reqs++;
        chk({v.name, ".mem_addr"}, 32'(mem_addr), 32'(v.result));
        chk({v.name, ".mem_rd"}, 32'(mem_rd), 32'(v.rd));
        if (v.wr) chk({v.name, ".mem_wdata"}, 32'(mem_wdata), 32'(v.wdata));
        if (reqs <= v.stall_n) begin
          mem_stall = 1'b1; mem_done = 1'b0;
        end else begin
          mem_stall = 1'b0; mem_done = (v.wait_n == 0); in_wait = 1;
        end
      end else if (in_wait) begin
        wcnt++;
        mem_stall = 1'b0; mem_done = (wcnt == v.wait_n);
      end else begin
        mem_stall = 1'b0; mem_done = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    mem_stall = 1'b0; mem_done = 1'b0;
    chk({v.name, ".latency"}, 32'(lat), 32'(v.exp_lat));
    chk({v.name, ".reqs"}, 32'(reqs), 32'(v.exp_reqs));
    chk({v.name, ".err"}, 32'(err), 32'(v.exp_err));
    chk({v.name, ".wb_valid"}, 32'(wb_valid), 32'(!v.exp_err));
    chk({v.name, ".mem_req_off"}, 32'({mem_rd, mem_wr}), 32'd0);
    if (!v.exp_err) begin
      chk({v.name, ".wb_data"}, 32'(wb_data), 32'(v.exp_data));
      chk({v.name, ".wb_dest"}, 32'(wb_dest), 32'(v.dest));
      chk({v.name, ".wb_reg_wr"}, 32'(wb_reg_wr), 32'(v.exp_reg_wr));
      chk({v.name, ".wb_halt"}, 32'(wb_halt), 32'd0);
    end
    $display("vector %s: lat=%0d reqs=%0d err=%0b wb_data=0x%04h", v.name, lat, reqs, err, wb_data);
    if (err) do_reset();
  endtask

  initial begin
    //          name      result    wdata     rd wr dest rw stall wait rdata    exp_data  erw eer lat reqs
    vecs[0] = '{"add",     16'h1234, 16'h0000, 0, 0, 3'd3, 1, 0, 0,   16'h0000, 16'h1234, 1, 0, 0,  0};
    vecs[1] = '{"ld_slow", 16'h0040, 16'h0000, 1, 0, 3'd5, 1, 2, 3,   16'hBEEF, 16'hBEEF, 1, 0, 6,  3};
    vecs[2] = '{"st_fast", 16'h00A0, 16'h5555, 0, 1, 3'd1, 1, 0, 0,   16'h0000, 16'h00A0, 0, 0, 1,  1};
    vecs[3] = '{"ld_odd",  16'h0041, 16'h0000, 1, 0, 3'd2, 1, 0, 0,   16'h0000, 16'h0000, 0, 1, 0,  0};
    vecs[4] = '{"rd_wr",   16'h0050, 16'h1111, 1, 1, 3'd2, 1, 0, 0,   16'h0000, 16'h0000, 0, 1, 0,  0};
    vecs[5] = '{"ld_fast", 16'h0100, 16'h0000, 1, 0, 3'd6, 1, 0, 0,   16'hCAFE, 16'hCAFE, 1, 0, 1,  1};
    vecs[6] = '{"st_slow", 16'h0200, 16'hA5A5, 0, 1, 3'd4, 1, 1, 2,   16'h0000, 16'h0200, 0, 0, 4,  2};
    vecs[7] = '{"ld_tmo",  16'h0300, 16'h0000, 1, 0, 3'd1, 1, 0, 255, 16'h0000, 16'h0000, 0, 1, 17, 1};
    vecs[8] = '{"nowr",    16'hFFFF, 16'h0000, 0, 0, 3'd7, 0, 0, 0,   16'h0000, 16'hFFFF, 0, 0, 0,  0};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.wb_valid", 32'(wb_valid), 32'd0);
    chk("rst.outs", 32'({wb_data, wb_dest, wb_reg_wr, wb_halt, err, mem_rd, mem_wr}), 32'd0);
    chk("rst.mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst.ex_ready", 32'(ex_ready), 32'd1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Back-to-back non-memory ops, one per cycle.
    do_reset();
    drive_alu(16'h0A0A, 3'd1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("b2b.ex_ready", 32'(ex_ready), 32'd1);
      @(posedge clk); #1;
      chk("b2b.wb_valid", 32'(wb_valid), 32'd1);
      chk("b2b.wb_data", 32'(wb_data), 32'(16'h0A0A + 16'(i)));
      $display("b2b %0d: wb_data=0x%04h", i, wb_data);
      ex_result = ex_result + 16'd1;
    end
    ex_valid = 1'b0;

    // Backpressure for 4 cycles, then HALT.
    do_reset();
    wb_ready = 1'b0;
    drive_alu(16'h1111, 3'd2, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive_alu(16'h2222, 3'd3, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("bp.wb_valid", 32'(wb_valid), 32'd1);
      chk("bp.wb_data", 32'(wb_data), 32'h1111);
      chk("bp.wb_dest", 32'(wb_dest), 32'd2);
      chk("bp.ex_ready", 32'(ex_ready), 32'd0);
    end
    @(negedge clk);
    wb_ready = 1'b1;
    drive_alu(16'h0007, 3'd0, 1'b0, 1'b1);
    #1 chk("halt.ex_ready", 32'(ex_ready), 32'd1);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("halt.wb_valid", 32'(wb_valid), 32'd1);
    chk("halt.wb_halt", 32'(wb_halt), 32'd1);
    chk("halt.wb_data", 32'(wb_data), 32'h0007);
    $display("halt: wb_halt=%0b wb_data=0x%04h", wb_halt, wb_data);
    ex_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("halted.ex_ready", 32'(ex_ready), 32'd0);
      chk("halted.wb_valid", 32'(wb_valid), 32'd0);
    end
    ex_valid = 1'b0;

    // Reset in the middle of WAIT; a late mem_done must be ignored.
    do_reset();
    ex_valid = 1'b1; ex_result = 16'h0400; ex_rd_en = 1'b1; ex_dest = 3'd3; ex_reg_wr = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_rd_en = 1'b0;
    chk("mid.mem_rd", 32'(mem_rd), 32'd1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid.rst_outs", 32'({wb_valid, wb_data, err, mem_rd, mem_wr}), 32'd0);
    chk("mid.rst_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_done = 1'b1; mem_rdata = 16'hDEAD;
    @(posedge clk); #1;
    mem_done = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("mid.late_done", 32'({wb_valid, err}), 32'd0);
    end
    $display("reset mid-wait: wb_valid=%0b err=%0b", wb_valid, err);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_mis);
    $finish;
  end

endmodule
